spi_flash_reader: RTL and testbench

//  Command sequencer directly upstream of the byte-level SPI master. It accepts a read

---
 rtl/spi_flash_pkg.sv | 36 +++
 rtl/spi_flash_reader.sv | 196 +++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR read sequencer.
// Also holds the header byte selector used while shifting out the command.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEL,
    ST_TX,
    ST_WAIT,
    ST_OUT,
    ST_DESEL
  } state_t;

  localparam logic [7:0] CMD_READ_DEF = 8'h03;
  localparam logic [2:0] HDR_LEN      = 3'd4;
  localparam logic       REG_CTL      = 1'b0;
  localparam logic       REG_DATA     = 1'b1;

  // Byte to shift out for a given position: opcode, 3 address bytes, then filler.
  function automatic logic [7:0] tx_byte(input logic [2:0]  idx,
                                         input logic [7:0]  cmd,
                                         input logic [23:0] addr,
                                         input logic [7:0]  dummy);
    logic [7:0] b;
    case (idx)
      3'd0:    b = cmd;
      3'd1:    b = addr[23:16];
      3'd2:    b = addr[15:8];
      3'd3:    b = addr[7:0];
      default: b = dummy;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_reader.sv
// Read-command sequencer driving a byte-level SPI master register bus.
// Bus outputs are registered so each write strobe is visible during the state that owns it.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int         LEN_W     = 16,
  parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
  parameter logic       SS_ACTIVE = 1'b0,
  parameter logic [7:0] DUMMY_TX  = 8'hFF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [23:0]      i_req_addr,
  input  logic [LEN_W-1:0] i_req_len,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_last,
  output logic             o_busy,
  output logic             o_spi_addr,
  output logic             o_spi_cs,
  output logic             o_spi_we,
  output logic [7:0]       o_spi_dat,
  input  logic [7:0]       i_spi_dat,
  input  logic             i_spi_irq
);

  localparam logic [7:0] CTL_SEL   = {7'b0, SS_ACTIVE};
  localparam logic [7:0] CTL_DESEL = {7'b0, ~SS_ACTIVE};

  state_t           state_q, state_d;
  logic             init_wr_q, init_wr_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       idx_inc;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic             spi_cs_q, spi_cs_d;
  logic             spi_we_q, spi_we_d;
  logic             spi_addr_q, spi_addr_d;
  logic [7:0]       spi_dat_q, spi_dat_d;

  assign idx_inc = idx_q + 3'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_INIT;
      init_wr_q  <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      spi_cs_q   <= 1'b0;
      spi_we_q   <= 1'b0;
      spi_addr_q <= REG_CTL;
      spi_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_wr_q  <= init_wr_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      spi_cs_q   <= spi_cs_d;
      spi_we_q   <= spi_we_d;
      spi_addr_q <= spi_addr_d;
      spi_dat_q  <= spi_dat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_wr_d  = init_wr_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    spi_cs_d   = 1'b0;
    spi_we_d   = 1'b0;
    spi_addr_d = spi_addr_q;
    spi_dat_d  = spi_dat_q;

    case (state_q)
      ST_INIT: begin
        // First cycle after reset raises the deselect write, second cycle moves on.
        if (!init_wr_q) begin
          init_wr_d  = 1'b1;
          spi_cs_d   = 1'b1;
          spi_we_d   = 1'b1;
          spi_addr_d = REG_CTL;
          spi_dat_d  = CTL_DESEL;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (i_req_valid) begin
          addr_d = i_req_addr;
          rem_d  = i_req_len;
          idx_d  = 3'd0;
          if (i_req_len != '0) begin
            state_d    = ST_SEL;
            spi_cs_d   = 1'b1;
            spi_we_d   = 1'b1;
            spi_addr_d = REG_CTL;
            spi_dat_d  = CTL_SEL;
          end
        end
      end

      ST_SEL: begin
        state_d    = ST_TX;
        spi_cs_d   = 1'b1;
        spi_we_d   = 1'b1;
        spi_addr_d = REG_DATA;
        spi_dat_d  = tx_byte(idx_q, CMD_READ, addr_q, DUMMY_TX);
      end

      ST_TX: begin
        state_d    = ST_WAIT;
        spi_addr_d = REG_DATA;
      end

      ST_WAIT: begin
        if (i_spi_irq) begin
          if (idx_q < HDR_LEN) begin
            // Bytes clocked in while the header goes out carry no data.
            idx_d      = idx_inc;
            state_d    = ST_TX;
            spi_cs_d   = 1'b1;
            spi_we_d   = 1'b1;
            spi_addr_d = REG_DATA;
            spi_dat_d  = tx_byte(idx_inc, CMD_READ, addr_q, DUMMY_TX);
          end else begin
            rd_data_d  = i_spi_dat;
            rd_valid_d = 1'b1;
            rd_last_d  = (rem_q == LEN_W'(1));
            state_d    = ST_OUT;
          end
        end
      end

      ST_OUT: begin
        // No new byte is started until the consumer takes this one; SS stays asserted.
        if (i_rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (rem_q != '0) begin
            rem_d = rem_q - LEN_W'(1);
          end
          spi_cs_d = 1'b1;
          spi_we_d = 1'b1;
          if (rem_q == LEN_W'(1)) begin
            state_d    = ST_DESEL;
            spi_addr_d = REG_CTL;
            spi_dat_d  = CTL_DESEL;
          end else begin
            state_d    = ST_TX;
            spi_addr_d = REG_DATA;
            spi_dat_d  = tx_byte(idx_q, CMD_READ, addr_q, DUMMY_TX);
          end
        end
      end

      ST_DESEL: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_last   = rd_last_q;
  assign o_spi_cs    = spi_cs_q;
  assign o_spi_we    = spi_we_q;
  assign o_spi_addr  = spi_addr_q;
  assign o_spi_dat   = spi_dat_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader with a behavioural SPI master and NOR flash model.
// Expected read bytes are queued at request time and checked by an independent monitor.
module tb_spi_flash_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic        rd_ready = 1'b0;
  logic        model_irq = 1'b0;
  logic        spur_irq = 1'b0;
  logic [7:0]  rx_q = 8'h00;

  logic        req_ready, rd_valid, rd_last, busy;
  logic [7:0]  rd_data;
  logic        spi_addr, spi_cs, spi_we;
  logic [7:0]  spi_wdat, spi_rdat;

  int          n_chk = 0;
  int          n_fail = 0;
  int          strobe_cnt = 0;
  int          rx_cnt = 0;
  int          countdown = 0;
  int          flash_pos = 0;
  logic [23:0] faddr = '0;
  logic [7:0]  last_ctl = 8'h00;
  logic        ss_sel = 1'b0;
  logic [7:0]  mosi_log[$];
  logic [8:0]  exp_q[$];
  logic [8:0]  exp_e;
  logic [7:0]  exp_mosi[7];

  always #5 clk = ~clk;

  assign spi_rdat = spi_addr ? rx_q : 8'h00;

  spi_flash_reader dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_len   (req_len),
    .o_rd_valid  (rd_valid),
    .i_rd_ready  (rd_ready),
    .o_rd_data   (rd_data),
    .o_rd_last   (rd_last),
    .o_busy      (busy),
    .o_spi_addr  (spi_addr),
    .o_spi_cs    (spi_cs),
    .o_spi_we    (spi_we),
    .o_spi_dat   (spi_wdat),
    .i_spi_dat   (spi_rdat),
    .i_spi_irq   (model_irq | spur_irq)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) timeout_fail(name);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!rd_valid && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rd_valid) timeout_fail(name);
  endtask

  task automatic req(input logic [23:0] a, input logic [15:0] l);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    chk("req_ready_at_issue", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // SPI master + flash: tx write starts a byte, irq four cycles later, rx byte at addr 1.
  initial begin
    forever begin
      @(posedge clk); #1;
      model_irq = 1'b0;
      if (rst) begin
        countdown = 0;
        flash_pos = 0;
        ss_sel    = 1'b0;
      end else if (spi_cs && spi_we) begin
        strobe_cnt++;
        if (!spi_addr) begin
          last_ctl = spi_wdat;
          ss_sel   = (spi_wdat[0] == 1'b0);
          if (!ss_sel) flash_pos = 0;
        end else begin
          mosi_log.push_back(spi_wdat);
          if (!ss_sel) rx_q = 8'hFF;
          else if (flash_pos == 0) rx_q = 8'hC3;
          else if (flash_pos < 4) begin
            faddr = {faddr[15:0], spi_wdat};
            rx_q  = 8'hC3;
          end else begin
            rx_q = mem_byte(faddr + 24'(flash_pos - 4));
          end
          if (ss_sel) flash_pos++;
          countdown = 4;
        end
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) model_irq = 1'b1;
      end
    end
  end

  // Monitor: compare every accepted output byte against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rd_valid && rd_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, required no output", rd_data);
        end else begin
          exp_e = exp_q.pop_front();
          chk("rd_last_data", 32'({rd_last, rd_data}), 32'(exp_e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, bad;
    logic [7:0] d0;
    exp_mosi = '{8'h03, 8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF, 8'hFF};

    // 1: reset values, then a single deselect write from INIT
    cycles(3);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_spi_cs", 32'(spi_cs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    strobe_cnt = 0;
    rst = 1'b0;
    wait_ready("init_ready");
    chk("init_strobes", 32'(strobe_cnt), 32'd1);
    chk("init_ctl", 32'(last_ctl), 32'h01);
    chk("init_busy", 32'(busy), 32'd0);

    // 2: basic 3-byte read
    mosi_log.delete();
    rd_ready = 1'b1;
    req(24'h012345, 16'd3);
    exp_q.push_back({1'b0, 8'h3C});
    exp_q.push_back({1'b0, 8'h3F});
    exp_q.push_back({1'b1, 8'h3E});
    chk("sel_strobe", 32'({spi_cs, spi_we, spi_addr, spi_wdat}), 32'({3'b110, 8'h00}));
    wait_ready("read3_done");
    chk("read3_mosi_cnt", 32'(mosi_log.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < mosi_log.size()) chk("read3_mosi", 32'(mosi_log[i]), 32'(exp_mosi[i]));
    end
    chk("read3_bytes", 32'(rx_cnt), 32'd3);
    chk("read3_ss_released", 32'(ss_sel), 32'd0);
    chk("read3_ctl", 32'(last_ctl), 32'h01);

    // 3: consumer stall on first byte
    rd_ready = 1'b0;
    req(24'h000100, 16'd2);
    exp_q.push_back({1'b0, 8'h5B});
    exp_q.push_back({1'b1, 8'h5A});
    wait_valid("stall_valid");
    s0  = strobe_cnt;
    d0  = rd_data;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (rd_data !== d0 || !rd_valid) bad++;
    end
    chk("stall_data_stable", 32'(bad), 32'd0);
    chk("stall_no_strobe", 32'(strobe_cnt), 32'(s0));
    chk("stall_ss_held", 32'(ss_sel), 32'd1);
    rd_ready = 1'b1;
    wait_ready("stall_done");
    chk("stall_bytes", 32'(rx_cnt), 32'd5);

    // 4: zero-length request is a no-op
    s0 = strobe_cnt;
    r0 = rx_cnt;
    req(24'h123456, 16'd0);
    chk("len0_ready", 32'(req_ready), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycles(1);
      if (rd_valid) bad++;
    end
    chk("len0_no_valid", 32'(bad), 32'd0);
    chk("len0_no_strobe", 32'(strobe_cnt), 32'(s0));
    chk("len0_no_bytes", 32'(rx_cnt), 32'(r0));

    // 5: reset during byte 2 of 5, then a fresh 1-byte read
    r0 = rx_cnt;
    req(24'h0002F0, 16'd5);
    exp_q.push_back({1'b0, 8'hA8});
    for (int i = 0; i < 2000 && rx_cnt == r0; i++) cycles(1);
    if (rx_cnt == r0) timeout_fail("abort_first_byte");
    cycles(2);
    rst = 1'b1;
    cycles(1);
    chk("abort_rd_valid", 32'(rd_valid), 32'd0);
    chk("abort_rd_last", 32'(rd_last), 32'd0);
    chk("abort_spi_bus", 32'({spi_cs, spi_we, spi_addr, spi_wdat}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    cycles(2);
    strobe_cnt = 0;
    rst = 1'b0;
    wait_ready("abort_init");
    chk("abort_init_strobes", 32'(strobe_cnt), 32'd1);
    chk("abort_init_ctl", 32'(last_ctl), 32'h01);
    req(24'hFFFFFF, 16'd1);
    exp_q.push_back({1'b1, 8'h5A});
    wait_ready("after_abort_done");
    chk("after_abort_bytes", 32'(rx_cnt), 32'(r0 + 2));

    // 6: spurious irq in IDLE and in OUT
    s0 = strobe_cnt;
    r0 = rx_cnt;
    spur_irq = 1'b1;
    cycles(1);
    spur_irq = 1'b0;
    cycles(10);
    chk("spur_idle_bytes", 32'(rx_cnt), 32'(r0));
    chk("spur_idle_strobes", 32'(strobe_cnt), 32'(s0));
    rd_ready = 1'b0;
    req(24'h000010, 16'd1);
    exp_q.push_back({1'b1, 8'h4A});
    wait_valid("spur_out_valid");
    s0 = strobe_cnt;
    spur_irq = 1'b1;
    cycles(1);
    spur_irq = 1'b0;
    cycles(5);
    chk("spur_out_strobes", 32'(strobe_cnt), 32'(s0));
    chk("spur_out_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    wait_ready("spur_out_done");
    cycles(10);
    chk("spur_out_bytes", 32'(rx_cnt), 32'(r0 + 1));
    chk("total_bytes", 32'(rx_cnt), 32'd8);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
